// File: rtl/cdc_pkg.sv
// Shared types and defaults for the toggle req/ack CDC transmitter.
// State encoding, parameter defaults and a counter-width helper.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } tx_state_e;

    localparam int M_DEF           = 2;
    localparam int SETUP_CYC_DEF   = 1;
    localparam int TIMEOUT_CYC_DEF = 1024;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Upstream valid/ready plus toggle req/ack bundle of cdc_hs_tx.
// Optional macro CDC_HS_TX_TIMEOUT_EN adds the timeout_err signal.
interface cdc_hs_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_req;
    logic                  tx_ack;
    logic                  busy;
    logic                  done;
`ifdef CDC_HS_TX_TIMEOUT_EN
    logic                  timeout_err;
`endif

    modport master (
        input  in_valid,
        input  in_data,
        input  tx_ack,
        output in_ready,
        output tx_data,
        output tx_req,
        output busy,
`ifdef CDC_HS_TX_TIMEOUT_EN
        output timeout_err,
`endif
        output done
    );

    modport slave (
        output in_valid,
        output in_data,
        output tx_ack,
        input  in_ready,
        input  tx_data,
        input  tx_req,
        input  busy,
`ifdef CDC_HS_TX_TIMEOUT_EN
        input  timeout_err,
`endif
        input  done
    );

endinterface

// File: rtl/cdc_ack_sync.sv
// M-stage flop synchronizer for the asynchronous ack toggle.
// Synchronous active-high reset clears every stage.
module cdc_ack_sync #(
    parameter int M          = 2,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] chain [M];

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < M; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < M; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[M-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side transmitter of a two-phase toggle req/ack CDC handshake.
// Optional macro CDC_HS_TX_TIMEOUT_EN adds a sticky ack-wait timeout flag.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int M           = M_DEF,
    parameter int SETUP_CYC   = SETUP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic         clk,
    input logic         reset,
    cdc_hs_tx_if.master bus
);

    localparam int CW = cnt_w(SETUP_CYC);

    // Empty block marks an illegal parameter set in elaboration reports.
    if (M < 2 || SETUP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_err
    end

    tx_state_e             state;
    tx_state_e             state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req_q;
    logic [CW-1:0]         cnt_q;
    logic                  ack_sync;
    logic                  match;
    logic                  accept;
    logic                  launch;
    logic                  in_ready;
    logic                  busy;
    logic                  done;

    cdc_ack_sync #(
        .M          (M),
        .DATA_WIDTH (1)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.tx_ack),
        .q     (ack_sync)
    );

    assign match  = (ack_sync == req_q);
    assign accept = in_ready && bus.in_valid;
    assign launch = (state == SETUP) && (cnt_q == '0);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = SETUP;
            SETUP:    if (launch) state_nxt = WAIT_ACK;
            WAIT_ACK: if (match)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from the current state
    always_comb begin
        in_ready = !reset && (state == IDLE);
        busy     = (state != IDLE);
        done     = !reset && (state == WAIT_ACK) && match;
    end

    // launch register, request toggle and setup countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            req_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= bus.in_data;
            cnt_q  <= CW'(SETUP_CYC - 1);
        end else if (launch) begin
            req_q  <= ~req_q;
        end else if (state == SETUP) begin
            cnt_q  <= cnt_q - 1'b1;
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wcnt_q;
    logic          terr_q;

    // count unanswered wait cycles; the error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
            terr_q <= 1'b0;
        end else if (launch) begin
            wcnt_q <= '0;
        end else if (state == WAIT_ACK && !match &&
                     wcnt_q != TW'(TIMEOUT_CYC)) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == TW'(TIMEOUT_CYC - 1)) terr_q <= 1'b1;
        end
    end

    assign bus.timeout_err = terr_q;
`endif

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.tx_data  = data_q;
    assign bus.tx_req   = req_q;

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-domain transmitter for a two-phase (toggle) req/ack clock-domain-crossing handshake.
- Accepts a word on a valid/ready interface and launches it on a registered data bus held stable for the whole transaction.
- Toggles tx_req to announce the word, then waits for the destination's tx_ack toggle, synchronized locally through M flops.
- The destination side synchronizes tx_req with an M-flop synchronizer and samples tx_data on a detected req toggle.

Parameters:
- DATA_WIDTH, 8: width of the transferred word.
- M, 2: depth of the ack synchronizer chain (>= 2).
- SETUP_CYC, 1: clk cycles between the tx_data update and the tx_req toggle (>= 1).
- TIMEOUT_CYC, 1024: ack-wait limit in clk cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  source-domain clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word; = (state==IDLE)
- in_data  in  DATA_WIDTH  upstream word
- tx_data  out  DATA_WIDTH  registered data to destination domain
- tx_req  out  1  registered request toggle
- tx_ack  in  1  acknowledge toggle from destination domain (asynchronous)
- busy  out  1  = (state!=IDLE)
- done  out  1  one-cycle pulse: transaction acknowledged

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset (sampled at clk edge):
  - state=IDLE, tx_data=0, tx_req=0, ack sync flops=0, setup counter=0, done=0.
  - in_ready=1 from the first cycle after reset deasserts. While reset is high, in_ready=0.
- States: IDLE, SETUP, WAIT_ACK.
- IDLE:
  - in_valid&&in_ready at an edge: tx_data<=in_data, counter<=SETUP_CYC-1, go to SETUP.
  - in_data is ignored at all other times.
- SETUP:
  - If counter==0: tx_req<=~tx_req and go to WAIT_ACK.
  - Else: decrement counter.
  - tx_req therefore toggles SETUP_CYC cycles after tx_data changes.
- WAIT_ACK:
  - ack_sync is the last flop of the M-stage chain fed by tx_ack.
  - When ack_sync==tx_req: done=1 (combinational, that cycle only) and go to IDLE at that edge.
  - in_ready is 1 in the following cycle.
- tx_data invariants:
  - tx_data changes only on acceptance in IDLE.
  - tx_data is constant while busy=1.
- Ack mismatches outside WAIT_ACK (ack_sync!=tx_req in IDLE or SETUP) are a protocol violation. They cause no state change.
- Latency from accept to the next in_ready=1: SETUP_CYC + 1 + destination response time + M cycles.
- Reset mid-transaction aborts the transaction: tx_req returns to 0, tx_data to 0, and the word is lost. The destination domain must be reset concurrently (system requirement).
- Simultaneous in_valid and done: the new word is not accepted in the done cycle. It is accepted in the next cycle, when in_ready=1.
- Bench assertions:
  - tx_data stable while busy.
  - tx_req toggles only on the SETUP->WAIT_ACK transition.
  - done implies state==WAIT_ACK.

Optional Feature:
- Macro: CDC_HS_TX_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit) and a wait counter of width $clog2(TIMEOUT_CYC+1).
  - The counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYC without a match, timeout_err is set. It is sticky and cleared only by reset.
  - The state machine keeps waiting; there is no auto-abort.
- Undefined: no port, no counter, no timeout behaviour.

Decomposition:
- Package cdc_pkg:
  - typedef enum logic [1:0] tx_state_e {IDLE, SETUP, WAIT_ACK}.
  - Default constants for M, SETUP_CYC and TIMEOUT_CYC.
- Sub-module cdc_ack_sync: M-stage flop chain with synchronous active-high reset, parameters M and DATA_WIDTH=1. Instantiated once for tx_ack.

Test Plan (DATA_WIDTH=8, M=2, SETUP_CYC=1 unless noted):
- Reset: hold reset 3 cycles with tx_ack=0 -> tx_req=0, tx_data=0x00, busy=0, in_ready=0 during reset and 1 the first cycle after.
- Single transfer: in_data=0xA5 with in_valid at cycle 0 -> tx_data=0xA5 from cycle 1, tx_req=1 from cycle 2; toggle tx_ack to 1 at cycle 6 -> done=1 exactly one cycle, 2 cycles later; in_ready=1 the next cycle.
- Back-to-back: in_valid held with 0x01 then 0x02, ack echoed after 3 cycles -> second accept only after done; tx_req sequence 0->1->0; tx_data 0x01 then 0x02.
- Upstream churn while busy: in_data changes every cycle during SETUP and WAIT_ACK -> tx_data holds the accepted value; in_ready=0 until done.
- Reset mid WAIT_ACK (tx_req=1): assert reset -> next cycle tx_req=0, tx_data=0x00, state IDLE; a late tx_ack toggle produces no done.
- With CDC_HS_TX_TIMEOUT_EN and TIMEOUT_CYC=16: tx_ack never toggles -> timeout_err rises 16 cycles after entering WAIT_ACK and stays 1; a later tx_ack toggle gives done, and timeout_err stays 1 until reset.
